fft_frame_ctrl: RTL
===================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter FFT_LENGTH, default 1024, FFT frame length (power of 2, at least 8).
REQ-002 SHALL have parameter FFT_DW, default 16, sample and bin width.
REQ-003 SHALL have parameter DMA_LAT, default 4, cycles from dmaa_o issue to valid dmadr_*_i (1..8).
REQ-004 SHALL have derived parameter FFT_N = clog2(FFT_LENGTH), not overridden.
REQ-005 SHALL have port clk, input, 1, the only clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port enable_i, input, 1, permits new frame start.
REQ-008 SHALL have ports sample_valid_i (input, 1) and sample_i (input, FFT_DW, signed), audio sample stream.
REQ-009 SHALL have ports input_stream_active_o (output, 1) and input_real_o (output, FFT_DW), FFT input stream.
REQ-010 SHALL have port run_o, output, 1, FFT start pulse.
REQ-011 SHALL have ports done_i (input, 1) and bfpexp_i (input, 8, signed), FFT completion and block exponent.
REQ-012 SHALL have ports dmaact_o (output, 1) and dmaa_o (output, FFT_N), FFT result read bus.
REQ-013 SHALL have ports dmadr_real_i and dmadr_imag_i, input, FFT_DW each, read data.
REQ-014 SHALL have ports bin_valid_o (output, 1) and bin_ready_i (input, 1), output bin handshake.
REQ-015 SHALL have ports bin_idx_o (output, FFT_N-1), bin_real_o and bin_imag_o (output, FFT_DW), bin_last_o (output, 1).
REQ-016 SHALL have ports frame_exp_o (output, 8), busy_o (output, 1), overrun_o (output, 1, sticky).

Function
REQ-017 SHALL implement states IDLE, FILL, RUN, WAIT, READ, DRAIN.
REQ-018 IDLE -> FILL when enable_i = 1; sample counter cleared.
REQ-019 In FILL, input_stream_active_o = sample_valid_i and input_real_o = sample_i, both registered one cycle; each valid sample increments the counter; after sample FFT_LENGTH -> RUN.
REQ-020 In RUN, run_o SHALL be 1 for exactly one cycle, then -> WAIT.
REQ-021 In WAIT, on done_i = 1 frame_exp_o SHALL latch bfpexp_i, then -> READ; done_i outside WAIT is ignored.
REQ-022 READ SHALL issue dmaact_o = 1 with dmaa_o = 0..FFT_LENGTH/2-1 in ascending order, one address per cycle at most.
REQ-023 A read SHALL issue only if outstanding reads plus output FIFO occupancy is less than DMA_LAT+2 (FIFO depth); no data is ever dropped.
REQ-024 Read data SHALL be captured exactly DMA_LAT cycles after issue into the FIFO, tagged with its address.
REQ-025 After the last address is issued -> DRAIN; DRAIN -> IDLE when no reads are outstanding and the FIFO is empty.
REQ-026 bin_* SHALL present the FIFO head; transfer occurs when bin_valid_o and bin_ready_i are both 1; bin_valid_o SHALL stay high and data stable until transfer.
REQ-027 bin_last_o SHALL be 1 only with bin_idx_o = FFT_LENGTH/2-1.
REQ-028 A sample_valid_i outside FILL SHALL set overrun_o; it is cleared only by reset.
REQ-029 busy_o SHALL be 1 in every state except IDLE.
REQ-030 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.

Reset
REQ-031 On rst_i = 1 at a clock edge: state IDLE, counters, FIFO and in-flight read tags cleared; run_o, dmaact_o, input_stream_active_o, bin_valid_o, busy_o, overrun_o = 0; dmaa_o, input_real_o, frame_exp_o, bin_* data = 0.
REQ-032 Reset mid-frame SHALL abort the frame with no further bin output; read data returning after reset SHALL be discarded.

Configuration
REQ-033 With macro FFT_FRAME_CTRL_PEAK_EN defined, the block SHALL add outputs peak_valid_o (1), peak_idx_o (FFT_N-1) and peak_mag_o (FFT_DW+1); it tracks max of |re|+|im| over bins 1..FFT_LENGTH/2-1 of each frame (lowest index wins ties), and pulses peak_valid_o for one cycle on the transfer of bin_last_o.
REQ-034 Without the macro those ports and logic SHALL be absent, with all other behaviour identical.

Verification
REQ-035 FFT_LENGTH=8, 8 samples on consecutive cycles -> run_o one pulse after the 8th sample; no further input_stream_active_o.
REQ-036 done_i with bfpexp_i=-3, bin_ready_i=1 -> bins 0..3 in order, frame_exp_o=-3, bin_last_o only on idx 3, then busy_o=0.
REQ-037 bin_ready_i held 0 for 20 cycles in READ -> at most DMA_LAT+2 reads issued; on release, all 4 bins delivered intact and in order.
REQ-038 sample_valid_i=1 during WAIT -> overrun_o=1 and stays 1 until rst_i.
REQ-039 rst_i asserted in READ with 2 reads in flight -> bin_valid_o=0 next cycle; no bins emitted from the stale data.
REQ-040 PEAK_EN, bins 1..3 = (5,-2),(-4,4),(1,0) -> peak_idx_o=2, peak_mag_o=8 with peak_valid_o.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame controller around an FFT core: collects a frame of samples, starts the core,
// then streams the lower half of the spectrum out through a credit-limited read FIFO.
// Optional peak-bin tracker is enabled by defining FFT_FRAME_CTRL_PEAK_EN.
module fft_frame_ctrl #(
  parameter int FFT_LENGTH = 1024,
  parameter int FFT_DW     = 16,
  parameter int DMA_LAT    = 4,
  localparam int FFT_N     = $clog2(FFT_LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     sample_valid_i,
  input  logic signed [FFT_DW-1:0] sample_i,
  output logic                     input_stream_active_o,
  output logic [FFT_DW-1:0]        input_real_o,
  output logic                     run_o,
  input  logic                     done_i,
  input  logic signed [7:0]        bfpexp_i,
  output logic                     dmaact_o,
  output logic [FFT_N-1:0]         dmaa_o,
  input  logic [FFT_DW-1:0]        dmadr_real_i,
  input  logic [FFT_DW-1:0]        dmadr_imag_i,
  output logic                     bin_valid_o,
  input  logic                     bin_ready_i,
  output logic [FFT_N-2:0]         bin_idx_o,
  output logic [FFT_DW-1:0]        bin_real_o,
  output logic [FFT_DW-1:0]        bin_imag_o,
  output logic                     bin_last_o,
  output logic [7:0]               frame_exp_o,
  output logic                     busy_o,
  output logic                     overrun_o
`ifdef FFT_FRAME_CTRL_PEAK_EN
  ,
  output logic                     peak_valid_o,
  output logic [FFT_N-2:0]         peak_idx_o,
  output logic [FFT_DW:0]          peak_mag_o
`endif
);

  localparam int HALF  = FFT_LENGTH / 2;
  localparam int IW    = FFT_N - 1;
  localparam int DEPTH = DMA_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [FFT_N-1:0] LAST_SMP  = FFT_N'(FFT_LENGTH - 1);
  localparam logic [FFT_N-1:0] LAST_ADDR = FFT_N'(HALF - 1);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(HALF - 1);

  logic [2:0]        state_q, state_d;
  logic [FFT_N-1:0]  smp_cnt_q, smp_cnt_d;
  logic [FFT_N-1:0]  rd_addr_q, rd_addr_d;
  logic [7:0]        frame_exp_q;
  logic              overrun_q;
  logic              in_act_q;
  logic [FFT_DW-1:0] in_real_q;
  logic [CW-1:0]     out_cnt_q;
  logic [CW-1:0]     fifo_cnt_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [IW-1:0]     fifo_idx_q [DEPTH];
  logic [FFT_DW-1:0] fifo_re_q  [DEPTH];
  logic [FFT_DW-1:0] fifo_im_q  [DEPTH];
  logic [DMA_LAT-1:0] sr_v_q;
  logic [IW-1:0]     sr_tag_q [DMA_LAT];

  logic issue, cap, pop;

  // A read may only be launched if its data is guaranteed a FIFO slot on return.
  assign issue = (state_q == S_READ) &&
                 (({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < (CW+1)'(DEPTH));
  assign cap   = sr_v_q[DMA_LAT-1];
  assign pop   = bin_valid_o && bin_ready_i;

  assign dmaact_o              = issue;
  assign dmaa_o                = issue ? rd_addr_q : '0;
  assign run_o                 = (state_q == S_RUN);
  assign busy_o                = (state_q != S_IDLE);
  assign overrun_o             = overrun_q;
  assign frame_exp_o           = frame_exp_q;
  assign input_stream_active_o = in_act_q;
  assign input_real_o          = in_real_q;
  assign bin_valid_o           = (fifo_cnt_q != '0);
  assign bin_idx_o             = fifo_idx_q[rd_ptr_q];
  assign bin_real_o            = fifo_re_q[rd_ptr_q];
  assign bin_imag_o            = fifo_im_q[rd_ptr_q];
  assign bin_last_o            = bin_valid_o && (bin_idx_o == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: if (enable_i) begin
        state_d   = S_FILL;
        smp_cnt_d = '0;
      end
      S_FILL: if (sample_valid_i) begin
        if (smp_cnt_q == LAST_SMP) state_d = S_RUN;
        else smp_cnt_d = smp_cnt_q + FFT_N'(1);
      end
      S_RUN: state_d = S_WAIT;
      S_WAIT: if (done_i) begin
        state_d   = S_READ;
        rd_addr_d = '0;
      end
      S_READ: if (issue) begin
        rd_addr_d = rd_addr_q + FFT_N'(1);
        if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
      end
      S_DRAIN: if (out_cnt_q == '0 && fifo_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      smp_cnt_q   <= '0;
      rd_addr_q   <= '0;
      frame_exp_q <= '0;
      overrun_q   <= 1'b0;
      in_act_q    <= 1'b0;
      in_real_q   <= '0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      rd_addr_q <= rd_addr_d;
      if (state_q == S_WAIT && done_i) frame_exp_q <= bfpexp_i;
      if (sample_valid_i && state_q != S_FILL) overrun_q <= 1'b1;
      in_act_q <= (state_q == S_FILL) && sample_valid_i;
      if (state_q == S_FILL && sample_valid_i) in_real_q <= sample_i;
    end
  end

  // Issue tags ride a DMA_LAT-deep delay line; clearing it on reset drops stale returns.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sr_v_q    <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < DMA_LAT; i++) sr_tag_q[i] <= '0;
    end else begin
      sr_v_q[0]   <= issue;
      sr_tag_q[0] <= rd_addr_q[IW-1:0];
      for (int i = 1; i < DMA_LAT; i++) begin
        sr_v_q[i]   <= sr_v_q[i-1];
        sr_tag_q[i] <= sr_tag_q[i-1];
      end
      case ({issue, cap})
        2'b10:   out_cnt_q <= out_cnt_q + CW'(1);
        2'b01:   out_cnt_q <= out_cnt_q - CW'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_idx_q[i] <= '0;
        fifo_re_q[i]  <= '0;
        fifo_im_q[i]  <= '0;
      end
    end else begin
      if (cap) begin
        fifo_idx_q[wr_ptr_q] <= sr_tag_q[DMA_LAT-1];
        fifo_re_q[wr_ptr_q]  <= dmadr_real_i;
        fifo_im_q[wr_ptr_q]  <= dmadr_imag_i;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      case ({cap, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef FFT_FRAME_CTRL_PEAK_EN
  logic [FFT_DW-1:0] abs_re, abs_im;
  logic [FFT_DW:0]   mag, best_mag_q, peak_mag_q;
  logic [IW-1:0]     best_idx_q, peak_idx_q;
  logic              seen_q, peak_valid_q, take;

  assign abs_re = bin_real_o[FFT_DW-1] ? -bin_real_o : bin_real_o;
  assign abs_im = bin_imag_o[FFT_DW-1] ? -bin_imag_o : bin_imag_o;
  assign mag    = {1'b0, abs_re} + {1'b0, abs_im};
  // Strict compare in ascending bin order keeps the lowest index on ties; DC is excluded.
  assign take   = (bin_idx_o != '0) && (!seen_q || mag > best_mag_q);

  assign peak_valid_o = peak_valid_q;
  assign peak_idx_o   = peak_idx_q;
  assign peak_mag_o   = peak_mag_q;

  // The result is registered, so the pulse appears the cycle after the last bin transfers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      best_mag_q   <= '0;
      best_idx_q   <= '0;
      seen_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      peak_valid_q <= 1'b0;
      if (state_q == S_WAIT && done_i) begin
        seen_q <= 1'b0;
      end else if (pop && bin_idx_o != '0) begin
        if (bin_last_o) begin
          peak_valid_q <= 1'b1;
          peak_idx_q   <= take ? bin_idx_o : best_idx_q;
          peak_mag_q   <= take ? mag : best_mag_q;
          seen_q       <= 1'b0;
        end else if (take) begin
          best_mag_q <= mag;
          best_idx_q <= bin_idx_o;
          seen_q     <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
